// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse cursor controller.
package mouse_pkg;

  typedef enum logic [1:0] {
    S_B0 = 2'd0,
    S_B1 = 2'd1,
    S_B2 = 2'd2
  } state_e;

  // Header byte bit positions
  localparam int HDR_L   = 0;
  localparam int HDR_R   = 1;
  localparam int HDR_ONE = 3;
  localparam int HDR_XS  = 4;
  localparam int HDR_YS  = 5;
  localparam int HDR_XO  = 6;
  localparam int HDR_YO  = 7;

  localparam int ACC_W = 12;
  localparam logic signed [ACC_W-1:0] ACC_MAX   = 12'sh7FF;
  localparam logic signed [ACC_W-1:0] ACC_MIN   = 12'sh800;
  localparam logic signed [ACC_W:0]   ACC_MAX_X = 13'sd2047;
  localparam logic signed [ACC_W:0]   ACC_MIN_X = -13'sd2048;

  // Saturate a one-bit-wider sum back into the accumulator range.
  function automatic logic signed [ACC_W-1:0] acc_sat(input logic signed [ACC_W:0] v);
    if (v > ACC_MAX_X) begin
      return ACC_MAX;
    end else if (v < ACC_MIN_X) begin
      return ACC_MIN;
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mouse_pos_ctrl_pkt_rx.sv
// PS/2 mouse packet assembler: header/X/Y byte FSM and delta decode.
// Optional inter-byte timeout enabled by defining MOUSE_PKT_TIMEOUT_EN.
module mouse_pos_ctrl_pkt_rx
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              pkt_done_o,
  output logic signed [8:0] dx_o,
  output logic signed [8:0] dy_o,
  output logic              btn_l_o,
  output logic              btn_r_o,
  output logic              pkt_err_o
);

  state_e     state_q, state_d;
  logic       pkt_err_q, pkt_err_d;
  logic [7:0] hdr_q, xbyte_q;
  logic       hdr_we, x_we;
  logic       tmo_hit;

`ifdef MOUSE_PKT_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Inter-byte gap counter: runs mid-packet, restarts on every byte
  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 1'b1;
    tmo_hit   = 1'b0;
    if (rx_valid_i || (state_q == S_B0)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      tmo_cnt_d = '0;
      tmo_hit   = 1'b1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state logic; a late byte or bad header drops the packet with an error strobe
  always_comb begin
    state_d    = state_q;
    pkt_err_d  = 1'b0;
    pkt_done_o = 1'b0;
    hdr_we     = 1'b0;
    x_we       = 1'b0;
    case (state_q)
      S_B0: begin
        if (rx_valid_i) begin
          if (rx_data_i[HDR_ONE]) begin
            hdr_we  = 1'b1;
            state_d = S_B1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end
      S_B1: begin
        if (rx_valid_i) begin
          x_we    = 1'b1;
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (rx_valid_i) begin
          pkt_done_o = 1'b1;
          state_d    = S_B0;
        end
      end
      default: state_d = S_B0;
    endcase
    if (tmo_hit) begin
      state_d   = S_B0;
      pkt_err_d = 1'b1;
    end
  end

  // FSM state and error strobe registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_B0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  // Header and X byte holding registers (data only, no reset needed)
  always_ff @(posedge clk_i) begin
    if (hdr_we) hdr_q   <= rx_data_i;
    if (x_we)   xbyte_q <= rx_data_i;
  end

  // Deltas are valid while the Y byte is on the bus; overflowed axes read as zero
  assign dx_o      = hdr_q[HDR_XO] ? 9'sd0 : $signed({hdr_q[HDR_XS], xbyte_q});
  assign dy_o      = hdr_q[HDR_YO] ? 9'sd0 : $signed({hdr_q[HDR_YS], rx_data_i});
  assign btn_l_o   = hdr_q[HDR_L];
  assign btn_r_o   = hdr_q[HDR_R];
  assign pkt_err_o = pkt_err_q;

endmodule

// File: rtl/mouse_pos_ctrl.sv
// Cursor position controller: accumulates PS/2 motion and applies it,
// clamped to the canvas, once per frame. Optional packet timeout is
// enabled by defining MOUSE_PKT_TIMEOUT_EN.
module mouse_pos_ctrl
  import mouse_pkg::*;
#(
  parameter int COL_MIN     = 193,
  parameter int COL_MAX     = 447,
  parameter int ROW_MIN     = 113,
  parameter int ROW_MAX     = 367,
  parameter int COL_RST     = 320,
  parameter int ROW_RST     = 240,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       frame_start,
  output logic [8:0] mouse_row,
  output logic [9:0] mouse_col,
  output logic       btn_left,
  output logic       btn_right,
  output logic       pkt_err
);

  localparam logic signed [ACC_W:0] COL_MIN_S = (ACC_W+1)'(COL_MIN);
  localparam logic signed [ACC_W:0] COL_MAX_S = (ACC_W+1)'(COL_MAX);
  localparam logic signed [ACC_W:0] ROW_MIN_S = (ACC_W+1)'(ROW_MIN);
  localparam logic signed [ACC_W:0] ROW_MAX_S = (ACC_W+1)'(ROW_MAX);

  function automatic logic [9:0] clamp_col(input logic signed [ACC_W:0] v);
    if (v < COL_MIN_S)      return COL_MIN_S[9:0];
    else if (v > COL_MAX_S) return COL_MAX_S[9:0];
    else                    return v[9:0];
  endfunction

  function automatic logic [8:0] clamp_row(input logic signed [ACC_W:0] v);
    if (v < ROW_MIN_S)      return ROW_MIN_S[8:0];
    else if (v > ROW_MAX_S) return ROW_MAX_S[8:0];
    else                    return v[8:0];
  endfunction

  logic              pkt_done, pkt_l, pkt_r;
  logic signed [8:0] pkt_dx, pkt_dy;

  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [ACC_W:0]   base_x, base_y, sum_col, sum_row;
  logic [9:0]              col_q, col_d;
  logic [8:0]              row_q, row_d;
  logic                    btn_l_q, btn_l_d, btn_r_q, btn_r_d;

  mouse_pos_ctrl_pkt_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_pkt_rx (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .pkt_done_o (pkt_done),
    .dx_o       (pkt_dx),
    .dy_o       (pkt_dy),
    .btn_l_o    (pkt_l),
    .btn_r_o    (pkt_r),
    .pkt_err_o  (pkt_err)
  );

  // Frame-synced position update and saturating motion accumulation
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    col_d   = col_q;
    row_d   = row_q;
    btn_l_d = btn_l_q;
    btn_r_d = btn_r_q;
    sum_col = $signed({3'b000, col_q}) + {acc_x_q[ACC_W-1], acc_x_q};
    sum_row = $signed({4'b0000, row_q}) + {acc_y_q[ACC_W-1], acc_y_q};
    base_x  = {acc_x_q[ACC_W-1], acc_x_q};
    base_y  = {acc_y_q[ACC_W-1], acc_y_q};
    if (frame_start) begin
      col_d   = clamp_col(sum_col);
      row_d   = clamp_row(sum_row);
      acc_x_d = '0;
      acc_y_d = '0;
      // A packet landing with the frame starts the next accumulation period
      base_x  = '0;
      base_y  = '0;
    end
    if (pkt_done) begin
      // Screen rows grow downward while PS/2 +Y points up
      acc_x_d = acc_sat(base_x + {{4{pkt_dx[8]}}, pkt_dx});
      acc_y_d = acc_sat(base_y - {{4{pkt_dy[8]}}, pkt_dy});
      btn_l_d = pkt_l;
      btn_r_d = pkt_r;
    end
  end

  // Accumulator, cursor and button registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
      col_q   <= 10'(COL_RST);
      row_q   <= 9'(ROW_RST);
      btn_l_q <= 1'b0;
      btn_r_q <= 1'b0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      col_q   <= col_d;
      row_q   <= row_d;
      btn_l_q <= btn_l_d;
      btn_r_q <= btn_r_d;
    end
  end

  assign mouse_col = col_q;
  assign mouse_row = row_q;
  assign btn_left  = btn_l_q;
  assign btn_right = btn_r_q;

endmodule
